can_tx_frame_sequencer: RTL and testbench
=========================================

# can_tx_frame_sequencer

Sequences a CAN 2.0A (standard 11-bit ID) data or remote frame, one unstuffed bit per sample point, into the bit stuffer. It accepts a frame over a valid/ready handshake, computes the CRC-15 on the fly and gates stuffing on and off per field. It pauses for stuff-bit insertions and reports completion and ACK errors. It sits between the TX buffer/register file and the bit stuffer in the CAN transmit path.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- reset_mode  in  1  synchronous abort; forces IDLE
- sample_point  in  1  one-cycle pulse per bit time, shared with the stuffer
- tx_valid  in  1  frame request
- tx_ready  out  1  high in IDLE while reset_mode=0
- tx_id  in  11  identifier, MSB first on bus
- tx_rtr  in  1  remote frame flag
- tx_dlc  in  4  data length code
- tx_data  in  64  data bytes; byte 0 = [63:56], sent first, MSB first
- insert_stuff_bit  in  1  from stuffer; stuffer is emitting a stuff bit this sample point
- rx_bit  in  1  sampled bus level, valid at sample_point
- bit_stuffing_en  out  1  to stuffer
- tx_frame_tx_bit  out  1  raw bit to stuffer; 1 (recessive) when idle
- busy  out  1  high in any state other than IDLE
- tx_done  out  1  one-cycle pulse at end of IFS
- ack_error  out  1  one-cycle pulse, ACK slot read recessive

## Operation
- States: IDLE, SOF, ID(11), RTR, IDE, R0, DLC(4), DATA(8·N), CRC(15), CRC_DEL, ACK_SLOT, ACK_DEL, EOF(7), IFS(3). A 7-bit bit counter indexes multi-bit fields.
- Accept: tx_valid && tx_ready on a clock edge. This captures id/rtr/dlc/data, clears the CRC register to 0, and moves to SOF.
- N = 0 if tx_rtr; otherwise min(tx_dlc, 8). DLC > 8 is sent as-is in the DLC field, with 8 bytes of data. When N = 0, DLC goes directly to CRC.
- Field values:
  - SOF = 0; IDE = 0; R0 = 0; RTR = tx_rtr.
  - CRC = 15-bit CRC, MSB first.
  - CRC_DEL, ACK_SLOT, ACK_DEL, EOF and IFS = 1.
- tx_frame_tx_bit is combinational from state and counter.
- CRC-15 (polynomial 0x4599) updates at each advancing sample point, over the bits from SOF through the last DATA bit. Stuff bits are excluded.
- bit_stuffing_en = 1 in states SOF through CRC inclusive, otherwise 0.
- Advance rule, evaluated on sample_point:
  - If bit_stuffing_en && insert_stuff_bit: hold state, counter and CRC.
  - Otherwise: step to the next bit.
- Bus lag: the stuffer drives the bit it latched at the previous sample point. A registered tag records which field the latched bit belonged to, and is cleared if that bit was a stuff bit.
- ACK check: on sample_point with tag = ACK_SLOT and rx_bit = 1, pulse ack_error. The frame still completes.
- tx_done pulses on the clock edge leaving the last IFS bit to IDLE. A new frame may be accepted in the following cycle.
- reset_mode = 1 in any state: next state IDLE, counter 0, CRC 0, tag cleared, no pulses.
- If sample_point and an accept occur in the same cycle, the accept wins. SOF is presented from the next cycle and is first latched at the next sample_point.

## Timing
- Reset values:
  - tx_ready = 1
  - busy = 0
  - bit_stuffing_en = 0
  - tx_frame_tx_bit = 1
  - tx_done = 0
  - ack_error = 0
  - arb_lost = 0 (when compiled)
- Accept to SOF presented: 1 clk. All state changes occur only on sample_point edges, except accept and reset_mode.
- Frame length in sample points = 44 + 8N + S + 3 (IFS), where S = number of stuff bits inserted.
- Pulses last exactly one clk.

## Configuration
- CAN_TX_ARB_LOSS_EN:
  - Defined: adds output arb_lost (1 bit). On sample_point with tag ∈ {ID, RTR}, a latched bit of 1 and rx_bit = 0, the block pulses arb_lost and goes to IDLE the same edge. tx_frame_tx_bit returns to 1 and no tx_done is issued.
  - Undefined: no port; rx_bit is used only for the ACK check.

## Test plan
- Frame id=0x123, rtr=0, dlc=1, data=0xA5: the captured unstuffed stream equals the golden bits, CRC matches a reference model, tx_done fires once, busy falls on the same edge.
- id=0x000, dlc=0: the stuffer inserts stuff bits after runs of five 0s. The sequencer holds on each insert_stuff_bit, the unstuffed stream is unchanged, and bit_stuffing_en drops exactly at CRC_DEL.
- dlc=15, rtr=0: the DLC field carries 1111, 64 data bits are sent, and total length = 44+64+S+3.
- rx_bit = 1 at the ACK slot: ack_error pulses once and tx_done still fires. With rx_bit = 0: no ack_error.
- reset_mode asserted during DATA bit 10: IDLE on the next edge, tx_frame_tx_bit = 1, tx_ready = 1, and no tx_done.
- (CAN_TX_ARB_LOSS_EN) id=0x7FF, with rx_bit forced to 0 on ID bit 3: arb_lost pulses, IDLE, no tx_done. With the macro off, the frame completes normally.

Source files
------------

// File: rtl/can_tx_frame_sequencer.sv
// CAN 2.0A transmit frame sequencer: serialises one unstuffed bit per sample point into the bit stuffer.
// Optional macro CAN_TX_ARB_LOSS_EN adds the arb_lost output and arbitration-loss abort.
module can_tx_frame_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reset_mode,
  input  logic        sample_point,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [10:0] tx_id,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic        insert_stuff_bit,
  input  logic        rx_bit,
  output logic        bit_stuffing_en,
  output logic        tx_frame_tx_bit,
  output logic        busy,
  output logic        tx_done,
`ifdef CAN_TX_ARB_LOSS_EN
  output logic        arb_lost,
`endif
  output logic        ack_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  state_t      state, tag, next_field;
  logic [6:0]  cnt, field_len;
  logic [14:0] crc;
  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q, nbytes_q;
  logic [63:0] data_q;
  logic        accept, hold, last_bit;
  logic [3:0]  id_idx, crc_idx;
  logic [1:0]  dlc_idx;
  logic [5:0]  data_idx;
`ifdef CAN_TX_ARB_LOSS_EN
  logic        latched_bit, arb_hit;
`endif

  function automatic logic [14:0] crc15_step(input logic [14:0] c, input logic b);
    logic fb;
    fb = c[14] ^ b;
    return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  function automatic logic [3:0] payload_bytes(input logic rtr, input logic [3:0] dlc);
    if (rtr)              return 4'd0;
    else if (dlc > 4'd8)  return 4'd8;
    else                  return dlc;
  endfunction

  assign tx_ready        = (state == S_IDLE) && !reset_mode;
  assign accept          = tx_valid && tx_ready;
  assign busy            = (state != S_IDLE);
  assign bit_stuffing_en = state inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
  assign hold            = bit_stuffing_en && insert_stuff_bit;

  assign id_idx   = 4'd10 - cnt[3:0];
  assign crc_idx  = 4'd14 - cnt[3:0];
  assign dlc_idx  = 2'd3 - cnt[1:0];
  assign data_idx = 6'd63 - cnt[5:0];
`ifdef CAN_TX_ARB_LOSS_EN
  assign arb_hit  = (tag == S_ID || tag == S_RTR) && latched_bit && !rx_bit;
`endif

  always_comb begin
    tx_frame_tx_bit = 1'b1;
    case (state)
      S_SOF, S_IDE, S_R0: tx_frame_tx_bit = 1'b0;
      S_ID:               tx_frame_tx_bit = id_q[id_idx];
      S_RTR:              tx_frame_tx_bit = rtr_q;
      S_DLC:              tx_frame_tx_bit = dlc_q[dlc_idx];
      S_DATA:             tx_frame_tx_bit = data_q[data_idx];
      S_CRC:              tx_frame_tx_bit = crc[crc_idx];
      default:            tx_frame_tx_bit = 1'b1;
    endcase
  end

  always_comb begin
    field_len  = 7'd1;
    next_field = S_IDLE;
    case (state)
      S_SOF:      next_field = S_ID;
      S_ID:       begin field_len = 7'd11; next_field = S_RTR; end
      S_RTR:      next_field = S_IDE;
      S_IDE:      next_field = S_R0;
      S_R0:       next_field = S_DLC;
      S_DLC:      begin field_len = 7'd4; next_field = (nbytes_q == 4'd0) ? S_CRC : S_DATA; end
      S_DATA:     begin field_len = {nbytes_q, 3'b000}; next_field = S_CRC; end
      S_CRC:      begin field_len = 7'd15; next_field = S_CRC_DEL; end
      S_CRC_DEL:  next_field = S_ACK_SLOT;
      S_ACK_SLOT: next_field = S_ACK_DEL;
      S_ACK_DEL:  next_field = S_EOF;
      S_EOF:      begin field_len = 7'd7; next_field = S_IFS; end
      S_IFS:      begin field_len = 7'd3; next_field = S_IDLE; end
      default:    next_field = S_IDLE;
    endcase
    last_bit = (cnt == field_len - 7'd1);
  end

  // frame contents are captured once per accept and need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      id_q     <= tx_id;
      rtr_q    <= tx_rtr;
      dlc_q    <= tx_dlc;
      data_q   <= tx_data;
      nbytes_q <= payload_bytes(tx_rtr, tx_dlc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tag       <= S_IDLE;
      cnt       <= '0;
      crc       <= '0;
      tx_done   <= 1'b0;
      ack_error <= 1'b0;
`ifdef CAN_TX_ARB_LOSS_EN
      arb_lost    <= 1'b0;
      latched_bit <= 1'b1;
`endif
    end else begin
      tx_done   <= 1'b0;
      ack_error <= 1'b0;
`ifdef CAN_TX_ARB_LOSS_EN
      arb_lost  <= 1'b0;
`endif
      if (reset_mode) begin
        state <= S_IDLE;
        tag   <= S_IDLE;
        cnt   <= '0;
        crc   <= '0;
      end else if (accept) begin
        state <= S_SOF;
        tag   <= S_IDLE;
        cnt   <= '0;
        crc   <= '0;
      end else if (sample_point) begin
        // tag follows the bit the stuffer latches now; a stuff bit carries no field
        tag <= hold ? S_IDLE : state;
`ifdef CAN_TX_ARB_LOSS_EN
        latched_bit <= tx_frame_tx_bit;
`endif
        if (tag == S_ACK_SLOT && rx_bit)
          ack_error <= 1'b1;
`ifdef CAN_TX_ARB_LOSS_EN
        if (arb_hit) begin
          arb_lost <= 1'b1;
          state    <= S_IDLE;
          tag      <= S_IDLE;
          cnt      <= '0;
          crc      <= '0;
        end else
`endif
        if (busy && !hold) begin
          if (state inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA})
            crc <= crc15_step(crc, tx_frame_tx_bit);
          if (last_bit) begin
            state <= next_field;
            cnt   <= '0;
            if (state == S_IFS)
              tx_done <= 1'b1;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_can_tx_frame_sequencer.sv
// Self-checking bench for can_tx_frame_sequencer: golden frame bit lists, CRC by polynomial division, stuffer/bus model.
// Honours CAN_TX_ARB_LOSS_EN the same way as the design.
module tb_can_tx_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, reset_mode, sample_point, tx_valid, tx_ready;
  logic [10:0] tx_id;
  logic        tx_rtr;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        insert_stuff_bit, rx_bit;
  logic        bit_stuffing_en, tx_frame_tx_bit, busy, tx_done, ack_error, arb_lost;

  can_tx_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .reset_mode(reset_mode), .sample_point(sample_point),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id), .tx_rtr(tx_rtr),
    .tx_dlc(tx_dlc), .tx_data(tx_data), .insert_stuff_bit(insert_stuff_bit),
    .rx_bit(rx_bit), .bit_stuffing_en(bit_stuffing_en), .tx_frame_tx_bit(tx_frame_tx_bit),
    .busy(busy), .tx_done(tx_done),
`ifdef CAN_TX_ARB_LOSS_EN
    .arb_lost(arb_lost),
`endif
    .ack_error(ack_error)
  );
`ifndef CAN_TX_ARB_LOSS_EN
  assign arb_lost = 1'b0;
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          exp_q[$];
  bit          got_q[$];
  logic [14:0] exp_crc;
  int          nbytes, ack_idx, crc_last_idx;
  int          n_sp, n_stuff, n_done, n_ack, n_arb, en_bad, pulse_long;
  bit          finished;
  logic        busy_end;
  logic        last_bus, prev_bus;
  int          run_len, prev_idx;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Expected unstuffed frame; CRC is the remainder of M(x)*x^15 divided by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
  function automatic void build_frame(input logic [10:0] id, input logic rtr,
                                      input logic [3:0] dlc, input logic [63:0] data);
    bit          rem[$];
    logic [15:0] gen;
    int          msg_len;
    gen = 16'hC599;
    exp_q.delete();
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    exp_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) exp_q.push_back(id[i]);
    exp_q.push_back(rtr);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) exp_q.push_back(dlc[i]);
    for (int i = 0; i < nbytes * 8; i++) exp_q.push_back(data[63 - i]);
    msg_len = exp_q.size();
    rem = exp_q;
    for (int i = 0; i < 15; i++) rem.push_back(1'b0);
    for (int i = 0; i < msg_len; i++)
      if (rem[i])
        for (int j = 0; j < 16; j++) rem[i + j] = rem[i + j] ^ gen[15 - j];
    for (int j = 0; j < 15; j++) exp_crc[14 - j] = rem[msg_len + j];
    for (int j = 14; j >= 0; j--) exp_q.push_back(exp_crc[j]);
    for (int i = 0; i < 13; i++) exp_q.push_back(1'b1);
    ack_idx      = 35 + 8 * nbytes;
    crc_last_idx = 33 + 8 * nbytes;
  endfunction

  // One bit time: stuffer decision and bus level at the sample point, then pulse observation
  task automatic bit_time(input bit rule, input bit rnd, input bit acked, input int force_idx);
    logic b, en, ins, emitted;
    int   idx;
    @(negedge clk);
    en      = bit_stuffing_en;
    b       = tx_frame_tx_bit;
    ins     = en && ((rule && run_len >= 5) || (rnd && $urandom_range(0, 9) == 0));
    emitted = ins ? ~last_bus : b;
    if (!en) run_len = 0;
    else if (run_len > 0 && emitted == last_bus) run_len++;
    else run_len = 1;
    last_bus = emitted;
    rx_bit = ((acked && prev_idx == ack_idx) || (force_idx >= 0 && prev_idx == force_idx))
             ? 1'b0 : prev_bus;
    insert_stuff_bit = ins;
    sample_point     = 1'b1;
    if (busy) begin
      n_sp++;
      if (ins) begin
        n_stuff++;
        prev_idx = -1;
      end else begin
        idx = got_q.size();
        got_q.push_back(b);
        if (en !== (idx <= crc_last_idx)) en_bad++;
        prev_idx = idx;
      end
      prev_bus = emitted;
    end else begin
      prev_idx = -1;
      prev_bus = 1'b1;
    end
    @(negedge clk);
    sample_point     = 1'b0;
    insert_stuff_bit = 1'b0;
    if (tx_done) begin n_done++; finished = 1; busy_end = busy; end
    if (ack_error) n_ack++;
    if (arb_lost) begin n_arb++; finished = 1; busy_end = busy; end
    @(negedge clk);
    if (tx_done || ack_error || arb_lost) pulse_long++;
  endtask

  task automatic start_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input bit sp_at_accept);
    build_frame(id, rtr, dlc, data);
    got_q.delete();
    n_sp = 0; n_stuff = 0; n_done = 0; n_ack = 0; n_arb = 0; en_bad = 0; pulse_long = 0;
    finished = 0; busy_end = 1'b1;
    prev_bus = 1'b1; prev_idx = -1; last_bus = 1'b1; run_len = 0;
    @(negedge clk);
    check("ready_before_accept", tx_ready, 1);
    tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_data = data;
    tx_valid = 1'b1;
    sample_point = sp_at_accept;
    @(negedge clk);
    tx_valid = 1'b0;
    sample_point = 1'b0;
    tx_id = 11'($urandom); tx_rtr = 1'($urandom); tx_dlc = 4'($urandom); tx_data = {$urandom, $urandom};
    check("sof_presented", {busy, tx_frame_tx_bit}, 2'b10);
  endtask

  task automatic run_frame(input bit rule, input bit rnd, input bit acked, input int force_idx);
    for (int g = 0; g < 400 && !finished; g++) bit_time(rule, rnd, acked, force_idx);
    check("frame_finished", finished, 1);
  endtask

  task automatic check_complete(input string name, input bit acked);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) bad++;
    check({name, "_stream_len"}, got_q.size(), exp_q.size());
    check({name, "_stream_bits"}, bad, 0);
    check({name, "_sample_points"}, n_sp, 47 + 8 * nbytes + n_stuff);
    check({name, "_tx_done"}, n_done, 1);
    check({name, "_ack_error"}, n_ack, acked ? 0 : 1);
    check({name, "_busy_at_done"}, busy_end, 0);
    check({name, "_stuff_en"}, en_bad, 0);
    check({name, "_pulse_width"}, pulse_long, 0);
    check({name, "_idle_out"}, {tx_ready, tx_frame_tx_bit, bit_stuffing_en}, 3'b110);
  endtask

  initial begin
    logic [14:0] got_crc;
    logic [3:0]  got_dlc;
    logic [63:0] d;
    logic        r;
    logic [3:0]  dl;
    bit          ak;

    rst_n = 1'b0; reset_mode = 1'b0; sample_point = 1'b0; tx_valid = 1'b0;
    tx_id = '0; tx_rtr = 1'b0; tx_dlc = '0; tx_data = '0;
    insert_stuff_bit = 1'b0; rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_stuff_en", bit_stuffing_en, 0);
    check("rst_tx_bit", tx_frame_tx_bit, 1);
    check("rst_pulses", {tx_done, ack_error, arb_lost}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // id 0x123, one byte 0xA5, bus-rule stuffing, acknowledged
    start_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, -1);
    check_complete("f123", 1'b1);
    for (int j = 0; j < 15; j++) got_crc[14 - j] = got_q[19 + 8 * nbytes + j];
    check("f123_crc", got_crc, exp_crc);

    // all-dominant header forces stuffing; no data bytes
    start_frame(11'h000, 1'b0, 4'd0, 64'h0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, -1);
    check_complete("id0", 1'b1);
    check("id0_stuffed", n_stuff > 0, 1);

    // DLC 15 sent verbatim with 8 bytes of data
    d = {$urandom, $urandom};
    start_frame(11'($urandom), 1'b0, 4'd15, d, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, -1);
    check_complete("dlc15", 1'b1);
    for (int j = 0; j < 4; j++) got_dlc[3 - j] = got_q[15 + j];
    check("dlc15_field", got_dlc, 4'hF);

    // nobody acknowledges: ack_error once, frame still completes
    start_frame(11'h2A5, 1'b0, 4'd2, 64'h1234_5678_9ABC_DEF0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, -1);
    check_complete("noack", 1'b0);

    // reset_mode while DATA bit 10 is presented
    start_frame(11'($urandom), 1'b0, 4'd8, {$urandom, $urandom}, 1'b0);
    for (int g = 0; g < 200 && got_q.size() < 29; g++) bit_time(1'b0, 1'b1, 1'b1, -1);
    @(negedge clk);
    check("abort_in_data", {busy, tx_frame_tx_bit}, {1'b1, exp_q[29]});
    reset_mode = 1'b1;
    @(negedge clk);
    check("abort_idle", {busy, tx_frame_tx_bit, bit_stuffing_en}, 3'b010);
    reset_mode = 1'b0;
    #1;
    check("abort_ready", tx_ready, 1);
    n_done = 0;
    repeat (20) bit_time(1'b0, 1'b0, 1'b1, -1);
    check("abort_no_done", n_done, 0);

    // dominant bus level read back on ID bit 3
    start_frame(11'h7FF, 1'b0, 4'd2, {$urandom, $urandom}, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, 4);
`ifdef CAN_TX_ARB_LOSS_EN
    check("arb_lost_pulse", n_arb, 1);
    check("arb_busy", busy_end, 0);
    check("arb_bits_sent", got_q.size(), 6);
    repeat (5) bit_time(1'b0, 1'b0, 1'b1, -1);
    check("arb_no_done", n_done, 0);
    check("arb_idle_out", {tx_ready, tx_frame_tx_bit}, 2'b11);
`else
    check_complete("arb_off", 1'b1);
`endif

    // random frames, random stuff insertion, random ACK, optional sample point on the accept edge
    for (int k = 0; k < 6; k++) begin
      r  = ($urandom_range(0, 3) == 0);
      dl = 4'($urandom_range(0, 15));
      ak = 1'($urandom_range(0, 1));
      start_frame(11'($urandom), r, dl, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      run_frame(1'b0, 1'b1, ak, -1);
      check_complete("rand", ak);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
